pcpu_imem_loader: RTL
=====================

// Module: pcpu_imem_loader
// PURPOSE
//  Upstream feeder of the 16-bit pipeline CPU. It receives a program as a byte stream over a
//  valid/ready handshake and stores it in a 256x16 instruction memory. The CPU reads that
//  memory through an asynchronous read port. Once loading ends, the block pulses start and
//  holds enable, so the CPU executes from pc=0. It stops the CPU on host request.
// PARAMETERS
//  AW       8    instruction address width; memory depth = 2**AW words
//  DW       16   instruction word width; fixed at 2 bytes
//  CNT_W    16   width of the run-cycle counter
// PORTS
//  clock        in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  in_data      in   8      host byte
//  in_valid     in   1      host byte valid
//  in_ready     out  1      loader accepts byte; transfer = in_valid & in_ready
//  cpu_stop     in   1      host request: end RUN
//  i_addr       in   AW     CPU instruction fetch address
//  i_datain     out  DW     mem[i_addr], combinational (same-cycle read)
//  cpu_enable   out  1      to CPU enable
//  cpu_start    out  1      to CPU start; single-cycle pulse
//  words_loaded out  AW+1   words written in the last/current load
//  run_cycles   out  CNT_W  clock cycles spent in RUN, saturating
//  load_err     out  1      sticky checksum error (CONFIGURATION)
// BEHAVIOUR
//  Reset: every mem word = 16'h0000 (NOP). in_ready=0, cpu_enable=0, cpu_start=0,
//   words_loaded=0, run_cycles=0, load_err=0. FSM enters IDLE.
//  FSM states: IDLE, HI, LO, [CHK], START, RUN. in_ready=1 only in IDLE, HI, LO and CHK.
//  IDLE: the accepted byte N is the word count; N=0 means 2**AW words. On accept:
//   waddr=0, words_loaded=0, run_cycles=0, load_err=0, go HI.
//  HI: the accepted byte is latched as the high byte, go LO.
//  LO: on the accepted byte b, write mem[waddr] <= {hi,b} at the next edge.
//   waddr+1 and words_loaded+1 also update at that edge.
//   When words_loaded+1 == total, go START (or CHK); otherwise go HI.
//   waddr is AW bits and wraps to 0 only when total = 2**AW, which ends the load.
//  Words above the total keep their previous contents. They are not cleared.
//  START: cpu_start=1 and cpu_enable=1 for exactly one cycle, then go RUN.
//  RUN: cpu_enable=1 and cpu_start=0. run_cycles += 1 each cycle and saturates at all-ones.
//   On cpu_stop=1: cpu_enable=0 from the next cycle, go IDLE. run_cycles holds its value.
//  cpu_stop is ignored outside RUN.
//  In any state, in_valid=0 stalls the FSM. No partial word is written.
//  i_datain is combinational in every state. During a load cpu_enable=0, so CPU fetches have no effect.
//  A read and a write to the same address in the same cycle return the old word; the new word is visible after the edge.
//  Reset asserted mid-load or mid-run: memory clears and all outputs return to reset values immediately (asynchronously).
//  Latency: last data byte accepted at edge k -> cpu_start high in cycle k+1 (k+2 with CHK).
// CONFIGURATION
//  PCPU_LOADER_CHECKSUM_EN defined:
//   - CHK state follows the last LO byte and accepts one byte c.
//   - Expected value: XOR of N and all 2N data bytes.
//   - Match: go START.
//   - Mismatch: load_err=1 (sticky until the next IDLE count byte), no start pulse, go IDLE.
//  PCPU_LOADER_CHECKSUM_EN undefined: no CHK state; LO goes directly to START; load_err is tied to 0.
// TESTING
//  1 Reset, then send 02,48,01,08,00 -> mem[0]=16'h4801, mem[1]=16'h0800.
//    Then cpu_start is one cycle high, cpu_enable=1 and words_loaded=2.
//  2 Send N=00 and 512 bytes, where word i = {i[7:0],~i[7:0]} -> mem[255]=16'hFF00 and words_loaded=256.
//    waddr wraps to 0; exactly one start pulse.
//  3 Drop in_valid for 3 cycles between the HI and LO bytes -> no write during the gap; the word is correct afterwards.
//  4 In RUN for 10 cycles, then cpu_stop=1 -> run_cycles=10, cpu_enable=0, in_ready=1.
//    cpu_stop in IDLE -> no effect.
//  5 Assert reset mid-load after 3 bytes -> all outputs at reset values and mem[0]=0.
//    A following load of 01,12,34 works.
//  6 With CHECKSUM_EN, send 01,12,34,27 -> start pulse.
//    With CHECKSUM_EN, send 01,12,34,00 -> load_err=1, no start, FSM in IDLE.

Source files
------------

// File: rtl/pcpu_imem_loader_if.sv
// Host byte-stream channel feeding the instruction-memory loader.
interface pcpu_imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pcpu_imem_loader.sv
// Loads a program byte stream into a 2**AW x DW instruction memory, then starts and runs the CPU.
// Optional trailing XOR checksum byte enabled by defining PCPU_LOADER_CHECKSUM_EN.
module pcpu_imem_loader #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  pcpu_imem_loader_if.slave   host,
  input  logic                cpu_stop,
  input  logic [AW-1:0]       i_addr,
  output logic [DW-1:0]       i_datain,
  output logic                cpu_enable,
  output logic                cpu_start,
  output logic [AW:0]         words_loaded,
  output logic [CNT_W-1:0]    run_cycles,
  output logic                load_err
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
`ifdef PCPU_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_START,
    S_RUN
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] waddr;
  logic [7:0]    hi;
  logic [AW:0]   total;
  logic          accept, last_word;
  logic          load_start, hi_en, wr_en;
  logic          ready_next, start_next, enable_next;
`ifdef PCPU_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
  logic          chk_fail;
`endif

  assign accept    = host.in_valid & host.in_ready;
  assign last_word = (words_loaded + (AW+1)'(1)) == total;
  // Same-cycle read of an address being written returns the old word.
  assign i_datain  = mem[i_addr];

  always_comb begin
    state_next = state;
    load_start = 1'b0;
    hi_en      = 1'b0;
    wr_en      = 1'b0;
`ifdef PCPU_LOADER_CHECKSUM_EN
    chk_fail   = 1'b0;
`endif
    case (state)
      S_IDLE: if (accept) begin
        load_start = 1'b1;
        state_next = S_HI;
      end
      S_HI: if (accept) begin
        hi_en      = 1'b1;
        state_next = S_LO;
      end
      S_LO: if (accept) begin
        wr_en = 1'b1;
        if (last_word) begin
`ifdef PCPU_LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_START;
`endif
        end else begin
          state_next = S_HI;
        end
      end
`ifdef PCPU_LOADER_CHECKSUM_EN
      S_CHK: if (accept) begin
        if (host.in_data == csum) begin
          state_next = S_START;
        end else begin
          chk_fail   = 1'b1;
          state_next = S_IDLE;
        end
      end
`endif
      S_START: state_next = S_RUN;
      S_RUN:   if (cpu_stop) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    ready_next  = (state_next != S_START) && (state_next != S_RUN);
    start_next  = (state_next == S_START);
    enable_next = start_next || (state_next == S_RUN);
  end

  // State and handshake/CPU control outputs, registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      host.in_ready <= 1'b0;
      cpu_start     <= 1'b0;
      cpu_enable    <= 1'b0;
    end else begin
      state         <= state_next;
      host.in_ready <= ready_next;
      cpu_start     <= start_next;
      cpu_enable    <= enable_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waddr        <= '0;
      hi           <= '0;
      total        <= '0;
      words_loaded <= '0;
      run_cycles   <= '0;
    end else begin
      if (load_start) begin
        waddr        <= '0;
        words_loaded <= '0;
        run_cycles   <= '0;
        total        <= (host.in_data == 8'd0) ? (AW+1)'(DEPTH) : (AW+1)'(host.in_data);
      end
      if (hi_en) hi <= host.in_data;
      if (wr_en) begin
        waddr        <= waddr + AW'(1);
        words_loaded <= words_loaded + (AW+1)'(1);
      end
      if ((state == S_RUN) && (run_cycles != '1)) run_cycles <= run_cycles + CNT_W'(1);
    end
  end

`ifdef PCPU_LOADER_CHECKSUM_EN
  // Running XOR of the count byte and all data bytes; load_err is sticky until the next count byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum     <= '0;
      load_err <= 1'b0;
    end else begin
      if (load_start) begin
        csum     <= host.in_data;
        load_err <= 1'b0;
      end else if (hi_en || wr_en) begin
        csum     <= csum ^ host.in_data;
      end
      if (chk_fail) load_err <= 1'b1;
    end
  end
`else
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= DW'({hi, host.in_data});
    end
  end

endmodule
